pmem_line_responder: RTL and testbench

- Synthesizable responder for the cache-to-physical-memory line interface: pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_rdata and pmem_resp.
- Sits on the memory side of the cache and answers line-granular (256-bit) read and write requests after a fixed, parameterized latency.
- Backed by a small on-chip line store.
- Used as the pmem endpoint in cache unit benches and small integrations; exposes sticky protocol-error and request counters for checkers.

---
 rtl/pmem_line_responder.sv | 161 ++++++++++++++++
 tb/tb_pmem_line_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_line_responder.sv
// Purpose: line-granular (256-bit) pmem endpoint backed by a small on-chip line store.
// Latency: pmem_resp pulses LATENCY cycles after the request is accepted in IDLE.
// Backpressure: one transaction at a time; requests are held by the requester until pmem_resp.
module pmem_line_responder #(
    parameter int LINES   = 16,
    parameter int LATENCY = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pmem_read,
    input  logic             pmem_write,
    input  logic [31:0]      pmem_address,
    input  logic [255:0]     pmem_wdata,
    output logic [255:0]     pmem_rdata,
    output logic             pmem_resp,
    output logic             proto_err,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count
);

    localparam int IW = $clog2(LINES);
    // Counter holds at most LATENCY-1; one bit is enough when LATENCY is 1.
    localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cnt;
    logic              r_is_wr;
    logic [IW-1:0]     r_idx;
    logic [255:0]      r_wdata;
    logic [255:0]      r_rdata;
    logic              r_proto;
    logic [CNT_W-1:0]  r_rd_cnt;
    logic [CNT_W-1:0]  r_wr_cnt;
    logic [255:0]      r_store [LINES];

    logic              w_req;
    logic              w_accept;
    logic [IW-1:0]     w_addr_idx;
    logic              w_enter_rd;
    logic [IW-1:0]     w_rd_idx;
    logic              w_unused_addr;

    assign w_req         = pmem_read | pmem_write;
    assign w_accept      = (r_state == IDLE) && w_req;
    assign w_addr_idx    = pmem_address[5+IW-1:5];
    // Offset bits and aliasing upper bits are deliberately ignored.
    assign w_unused_addr = ^{pmem_address[31:5+IW], pmem_address[4:0]};

    // Next-state logic; also flags a read entering RESP so rdata can be captured on entry.
    always_comb begin
        w_next     = r_state;
        w_enter_rd = 1'b0;
        w_rd_idx   = r_idx;
        case (r_state)
            IDLE: begin
                w_rd_idx = w_addr_idx;
                if (w_req) begin
                    if (LATENCY == 1) begin
                        w_next     = RESP;
                        // Simultaneous read+write executes as a read.
                        w_enter_rd = pmem_read;
                    end else begin
                        w_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (r_cnt == CW'(1)) begin
                    w_next     = RESP;
                    w_enter_rd = ~r_is_wr;
                end
            end
            RESP: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Latch the request at acceptance and run the latency countdown while BUSY.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_is_wr <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_cnt   <= CW'(LATENCY - 1);
            r_is_wr <= pmem_write & ~pmem_read;
            r_idx   <= w_addr_idx;
            r_wdata <= pmem_wdata;
        end else if (r_state == BUSY) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // Line store: written at the edge ending RESP; contents are never reset.
    always_ff @(posedge clk) begin
        if ((r_state == RESP) && r_is_wr) begin
            r_store[r_idx] <= r_wdata;
        end
    end

    // Read data captured on entry to RESP and held until the next read completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (w_enter_rd) begin
            r_rdata <= r_store[w_rd_idx];
        end
    end

    // Sticky protocol error: read and write both asserted when sampled in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_proto <= 1'b0;
        end else if (w_accept && pmem_read && pmem_write) begin
            r_proto <= 1'b1;
        end
    end

    // Saturating completion counters, stepped in the RESP cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else if (r_state == RESP) begin
            if (r_is_wr) begin
                if (r_wr_cnt != '1) r_wr_cnt <= r_wr_cnt + CNT_W'(1);
            end else begin
                if (r_rd_cnt != '1) r_rd_cnt <= r_rd_cnt + CNT_W'(1);
            end
        end
    end

    assign pmem_resp  = (r_state == RESP);
    assign pmem_rdata = r_rdata;
    assign proto_err  = r_proto;
    assign rd_count   = r_rd_cnt;
    assign wr_count   = r_wr_cnt;

endmodule

// File: tb/tb_pmem_line_responder.sv
module tb_pmem_line_responder;

    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;

    // Instance 0: LATENCY=4, 16-bit counters. Instance 1: LATENCY=1, 2-bit counters.
    logic         rd0, wr0, rd1, wr1;
    logic [31:0]  ad0, ad1;
    logic [255:0] wd0, wd1;
    logic [255:0] rdat0, rdat1;
    logic         resp0, resp1, perr0, perr1;
    logic [15:0]  rc0, wc0;
    logic [1:0]   rc1, wc1;

    pmem_line_responder #(.LINES(16), .LATENCY(4), .CNT_W(16)) u_l4 (
        .clk(clk), .rst(rst),
        .pmem_read(rd0), .pmem_write(wr0), .pmem_address(ad0), .pmem_wdata(wd0),
        .pmem_rdata(rdat0), .pmem_resp(resp0), .proto_err(perr0),
        .rd_count(rc0), .wr_count(wc0)
    );

    pmem_line_responder #(.LINES(16), .LATENCY(1), .CNT_W(2)) u_l1 (
        .clk(clk), .rst(rst),
        .pmem_read(rd1), .pmem_write(wr1), .pmem_address(ad1), .pmem_wdata(wd1),
        .pmem_rdata(rdat1), .pmem_resp(resp1), .proto_err(perr1),
        .rd_count(rc1), .wr_count(wc1)
    );

    typedef struct {
        int           dut;
        bit           chk;
        logic [255:0] data;
        int           cyc;
    } exp_t;

    exp_t sb[$];

    localparam logic [255:0] DA5 = {32{8'hA5}};
    localparam logic [255:0] D1  = {8{32'h1111_C0DE}};
    localparam logic [255:0] D2  = {8{32'h2222_BEEF}};
    localparam logic [255:0] D3  = {8{32'h3333_F00D}};
    localparam logic [255:0] D4  = {8{32'h4444_0BAD}};
    localparam logic [255:0] D5  = {8{32'h5555_1234}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    // Scoreboard monitor: every resp pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                if ((k == 0) ? resp0 : resp1) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_resp dut=%0d cyc=%0d got resp with nothing expected", k, cyc);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        if (e.dut != k || e.cyc != cyc) begin
                            bad++;
                            $display("FAIL resp_timing dut=%0d cyc=%0d, required dut=%0d cyc=%0d", k, cyc, e.dut, e.cyc);
                        end
                        if (e.chk) begin
                            total++;
                            if (((k == 0) ? rdat0 : rdat1) !== e.data) begin
                                bad++;
                                $display("FAIL resp_rdata dut=%0d got=%h required=%h", k, (k == 0) ? rdat0 : rdat1, e.data);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic drive(input int k, input bit r, input bit w, input logic [31:0] a, input logic [255:0] d);
        if (k == 0) begin
            rd0 = r; wr0 = w; ad0 = a; wd0 = d;
        end else begin
            rd1 = r; wr1 = w; ad1 = a; wd1 = d;
        end
    endtask

    // One transaction: assert in an IDLE cycle, hold until resp, drop in the resp cycle.
    task automatic txn(input int k, input bit r, input bit w, input logic [31:0] a,
                       input logic [255:0] d, input bit chk, input logic [255:0] exp_d);
        exp_t e;
        int   n;
        bit   got;
        @(negedge clk);
        drive(k, r, w, a, d);
        e.dut  = k;
        e.chk  = chk & r;
        e.data = exp_d;
        e.cyc  = cyc + lat(k);
        sb.push_back(e);
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            got = (k == 0) ? resp0 : resp1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL resp_timeout dut=%0d addr=%h no resp within 20 cycles", k, a);
            void'(sb.pop_front());
        end
        drive(k, 1'b0, 1'b0, 32'h0, 256'h0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (resp0 !== 1'b0) begin bad++; $display("FAIL reset_resp got=%b required=0", resp0); end
        total++; if (rdat0 !== 256'h0) begin bad++; $display("FAIL reset_rdata got=%h required=0", rdat0); end
        total++; if (rc0 !== 16'h0 || wc0 !== 16'h0) begin bad++; $display("FAIL reset_counts rd=%0d wr=%0d required 0/0", rc0, wc0); end
        total++; if (perr0 !== 1'b0 || perr1 !== 1'b0) begin bad++; $display("FAIL reset_proto got=%b%b required=00", perr0, perr1); end
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (resp0 !== 1'b0 || resp1 !== 1'b0) begin
                bad++;
                $display("FAIL idle_resp cycle=%0d got=%b%b required=00", i, resp1, resp0);
            end
        end
        total++; if (rdat0 !== 256'h0 || rc0 !== 16'h0 || wc0 !== 16'h0) begin
            bad++; $display("FAIL idle_state rdata=%h rd=%0d wr=%0d required all 0", rdat0, rc0, wc0);
        end
    endtask

    task automatic test_write_read();
        txn(0, 1'b0, 1'b1, 32'h0000_0040, DA5, 1'b0, 256'h0);
        @(negedge clk);
        total++; if (wc0 !== 16'd1) begin bad++; $display("FAIL wr_count_after_write got=%0d required=1", wc0); end
        txn(0, 1'b1, 1'b0, 32'h0000_0040, 256'h0, 1'b1, DA5);
        @(negedge clk);
        total++; if (rc0 !== 16'd1) begin bad++; $display("FAIL rd_count_after_read got=%0d required=1", rc0); end
    endtask

    // Evict-then-load: the read follows in the first IDLE cycle after the write's resp.
    task automatic test_back_to_back();
        logic [15:0] rc_b, wc_b;
        rc_b = rc0;
        wc_b = wc0;
        txn(0, 1'b0, 1'b1, 32'h0000_0080, D1, 1'b0, 256'h0);
        txn(0, 1'b1, 1'b0, 32'h0000_0100, 256'h0, 1'b0, 256'h0);
        @(negedge clk);
        total++; if (rc0 !== rc_b + 16'd1 || wc0 !== wc_b + 16'd1) begin
            bad++; $display("FAIL evict_load_counts rd=%0d wr=%0d required rd=%0d wr=%0d", rc0, wc0, rc_b + 16'd1, wc_b + 16'd1);
        end
        txn(0, 1'b1, 1'b0, 32'h0000_0080, 256'h0, 1'b1, D1);
    endtask

    task automatic test_alias();
        txn(0, 1'b0, 1'b1, 32'h0000_0200, D2, 1'b0, 256'h0);
        txn(0, 1'b1, 1'b0, 32'h0000_001F, 256'h0, 1'b1, D2);
    endtask

    // Reset while BUSY: no resp, no store write, counters cleared.
    task automatic test_mid_reset();
        txn(0, 1'b0, 1'b1, 32'h0000_0040, DA5, 1'b0, 256'h0);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 32'h0000_0040, D5);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 256'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        total++; if (rc0 !== 16'h0 || wc0 !== 16'h0) begin bad++; $display("FAIL midreset_counts rd=%0d wr=%0d required 0/0", rc0, wc0); end
        total++; if (rdat0 !== 256'h0) begin bad++; $display("FAIL midreset_rdata got=%h required=0", rdat0); end
        txn(0, 1'b1, 1'b0, 32'h0000_0040, 256'h0, 1'b1, DA5);
    endtask

    // LATENCY=1 instance: read+write together, sticky error, no store write, saturating count.
    task automatic test_proto();
        txn(1, 1'b0, 1'b1, 32'h0000_0020, D3, 1'b0, 256'h0);
        @(negedge clk);
        total++; if (perr1 !== 1'b0 || wc1 !== 2'd1) begin bad++; $display("FAIL proto_pre err=%b wr=%0d required err=0 wr=1", perr1, wc1); end
        txn(1, 1'b1, 1'b1, 32'h0000_0020, D4, 1'b1, D3);
        @(negedge clk);
        total++; if (perr1 !== 1'b1) begin bad++; $display("FAIL proto_set got=%b required=1", perr1); end
        total++; if (rc1 !== 2'd1 || wc1 !== 2'd1) begin bad++; $display("FAIL proto_counts rd=%0d wr=%0d required 1/1", rc1, wc1); end
        txn(1, 1'b1, 1'b0, 32'h0000_0020, 256'h0, 1'b1, D3);
        txn(1, 1'b1, 1'b0, 32'h0000_0020, 256'h0, 1'b1, D3);
        txn(1, 1'b1, 1'b0, 32'h0000_0020, 256'h0, 1'b1, D3);
        @(negedge clk);
        total++; if (rc1 !== 2'd3) begin bad++; $display("FAIL rd_count_saturate got=%0d required=3", rc1); end
        total++; if (perr1 !== 1'b1) begin bad++; $display("FAIL proto_sticky got=%b required=1", perr1); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc   = 0;
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 256'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 256'h0);
        test_reset();
        test_write_read();
        test_back_to_back();
        test_alias();
        test_mid_reset();
        test_proto();
        repeat (5) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
